// File: rtl/bsg_mul_comp42_seq.sv
// Sequential unsigned multiplier. It retires two multiplier bits per cycle
// through a single 2*width_p-bit carry-save 4:2 compressor. A final
// carry-propagate add resolves the redundant sum/carry pair into the product.
// A valid/ready handshake accepts operands. A valid/yumi handshake returns
// the product.

// Carry-save 4:2 compressor built from two chained 3:2 rows. The carry
// output is returned already shifted to its true weight. Carries out of the
// top column are dropped, so the result is exact modulo 2^w.
module bsg_mul_comp42_seq_comp42 #(
  parameter int w = 32
) (
  input  logic [w-1:0] x0,
  input  logic [w-1:0] x1,
  input  logic [w-1:0] x2,
  input  logic [w-1:0] x3,
  output logic [w-1:0] sum,
  output logic [w-1:0] carry
);

  logic [w-1:0] s1;     // first-row sum
  logic [w-2:0] cout;   // first-row carries, top column dropped
  logic [w-1:0] cin;    // first-row carries at their true weight
  logic [w-2:0] c2;     // second-row carries, top column dropped

  assign s1    = x0 ^ x1 ^ x2;
  assign cout  = (x0[w-2:0] & x1[w-2:0])
               | (x0[w-2:0] & x2[w-2:0])
               | (x1[w-2:0] & x2[w-2:0]);
  assign cin   = {cout, 1'b0};
  assign sum   = s1 ^ x3 ^ cin;
  assign c2    = (s1[w-2:0] & x3[w-2:0])
               | (s1[w-2:0] & cin[w-2:0])
               | (x3[w-2:0] & cin[w-2:0]);
  assign carry = {c2, 1'b0};

endmodule

module bsg_mul_comp42_seq #(
  parameter int width_p     = 16,  // operand width; even, 4..64
  parameter int early_out_p = 1    // 1: stop once the remaining multiplier bits are zero
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [2*width_p-1:0]   p_o,
  input  logic                   yumi_i
);

  localparam int half_lp = width_p / 2;        // number of bit pairs
  localparam int kw_lp   = $clog2(half_lp);    // pair-counter width
  localparam int pw_lp   = 2 * width_p;        // product width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_r, state_n;

  logic [width_p-1:0] a_r;        // latched multiplicand
  logic [width_p-1:0] b_r;        // latched multiplier
  logic [pw_lp-1:0]   sum_r;      // carry-save sum accumulator
  logic [pw_lp-1:0]   carry_r;    // carry-save carry accumulator
  logic [pw_lp-1:0]   prod_r;     // resolved product
  logic [kw_lp-1:0]   k_r;        // index of the bit pair being retired

  // Bit positions of the current pair, b[2k] and b[2k+1].
  logic [kw_lp:0]     idx0, idx1;
  // First multiplier bit above the pair being retired: 2k+2.
  logic [kw_lp+1:0]   shamt;

  logic [pw_lp-1:0]   pp0, pp1;
  logic [pw_lp-1:0]   comp_sum, comp_carry;

  logic               last_pair;
  logic               early_done;
  logic               step_done;

  assign idx0  = {k_r, 1'b0};
  assign idx1  = {k_r, 1'b1};
  assign shamt = {1'b0, k_r, 1'b0} + (kw_lp+2)'(2);

  // Partial products for the current pair, aligned to bits 2k and 2k+1.
  assign pp0 = {{width_p{1'b0}}, a_r & {width_p{b_r[idx0]}}} << idx0;
  assign pp1 = {{(width_p-1){1'b0}}, a_r & {width_p{b_r[idx1]}}, 1'b0} << idx0;

  bsg_mul_comp42_seq_comp42 #(
    .w (pw_lp)
  ) comp (
    .x0    (sum_r),
    .x1    (carry_r),
    .x2    (pp0),
    .x3    (pp1),
    .sum   (comp_sum),
    .carry (comp_carry)
  );

  // The step in flight is the last one when it retires the top pair. With
  // early out, it is also the last one when no multiplier bit above the
  // pair is set. Shifting by width_p for the top pair yields zero, which
  // agrees with last_pair.
  assign last_pair  = (k_r == kw_lp'(half_lp - 1));
  assign early_done = (early_out_p != 0) && ((b_r >> shamt) == '0);
  assign step_done  = last_pair || early_done;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic for the accept / iterate / resolve / hand-off sequence.
  // NOTE: state_n gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (v_i)       state_n = BUSY;
      BUSY:    if (step_done) state_n = FINAL;
      FINAL:                  state_n = DONE;
      DONE:    if (yumi_i)    state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Datapath: capture operands, iterate the compressor, then resolve.
  // NOTE: all datapath registers are reset, not only the control state. A
  // reset taken mid-operation therefore cannot leave a stale partial result
  // that later reaches p_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      prod_r  <= '0;
      k_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            a_r     <= a_i;
            b_r     <= b_i;
            sum_r   <= '0;
            carry_r <= '0;
            k_r     <= '0;
          end
        end
        BUSY: begin
          sum_r   <= comp_sum;
          carry_r <= comp_carry;
          k_r     <= k_r + kw_lp'(1);
        end
        FINAL: begin
          // The product fits in pw_lp bits, so the add's carry-out is dropped.
          prod_r <= sum_r + carry_r;
        end
        default: begin
          // DONE holds the product steady until the consumer takes it.
        end
      endcase
    end
  end

  assign ready_o = (state_r == IDLE);
  assign v_o     = (state_r == DONE);
  assign p_o     = v_o ? prod_r : '0;

endmodule

// File: tb/tb_bsg_mul_comp42_seq.sv
// Self-checking bench for bsg_mul_comp42_seq. Directed width-8 scenarios use
// literal expectations. Two random streams (width 16 with early out, width 4
// without) are compared every cycle against a latency/product model.
module tb_bsg_mul_comp42_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of BUSY cycles, derived from the multiplier's bit length.
  function automatic int busy_cycles(input longint unsigned b, input int w, input bit eo);
    int len;
    len = 0;
    for (int i = 0; i < w; i++) if (b[i]) len = i + 1;
    if (!eo) return w / 2;
    return (len <= 2) ? 1 : (len + 1) / 2;
  endfunction

  // ---------------- directed width-8 instances ----------------
  logic       rst8_n = 1'b0;
  logic       sel    = 1'b0;  // 0: full-length instance, 1: early-out instance
  logic       d_v    = 1'b0;
  logic       d_yumi = 1'b0;
  logic [7:0] d_a    = '0;
  logic [7:0] d_b    = '0;

  logic        f_v, f_yumi, f_ready, f_vo;
  logic [15:0] f_p;
  logic        e_v, e_yumi, e_ready, e_vo;
  logic [15:0] e_p;
  logic        o_ready, o_vo;
  logic [15:0] o_p;

  assign f_v    = d_v & ~sel;
  assign f_yumi = d_yumi & ~sel;
  assign e_v    = d_v & sel;
  assign e_yumi = d_yumi & sel;
  assign o_ready = sel ? e_ready : f_ready;
  assign o_vo    = sel ? e_vo : f_vo;
  assign o_p     = sel ? e_p : f_p;

  bsg_mul_comp42_seq #(.width_p(8), .early_out_p(0)) dut_full (
    .clk_i(clk), .reset_n_i(rst8_n), .v_i(f_v), .a_i(d_a), .b_i(d_b),
    .ready_o(f_ready), .v_o(f_vo), .p_o(f_p), .yumi_i(f_yumi));

  bsg_mul_comp42_seq #(.width_p(8), .early_out_p(1)) dut_early (
    .clk_i(clk), .reset_n_i(rst8_n), .v_i(e_v), .a_i(d_a), .b_i(d_b),
    .ready_o(e_ready), .v_o(e_vo), .p_o(e_p), .yumi_i(e_yumi));

  // Called just after a negedge with the selected instance idle. The accept
  // happens at the next posedge (edge 0); v_o must first rise in cycle
  // exp_cyc. The product is then held for 'hold' cycles of backpressure
  // before yumi.
  task automatic run_d(input bit s, input logic [7:0] a, input logic [7:0] b,
                       input int exp_cyc, input logic [15:0] exp_p, input int hold);
    sel = s;
    check("d_ready_before_accept", o_ready, 1);
    d_v = 1'b1; d_a = a; d_b = b; d_yumi = 1'b0;
    for (int c = 1; c <= exp_cyc; c++) begin
      @(negedge clk);
      check("d_latency_v", o_vo, (c == exp_cyc));
      if (c < exp_cyc) begin
        check("d_busy_ready", o_ready, 0);
        check("d_busy_p_zero", o_p, 0);
        // Junk operands and a stray yumi while busy must be ignored.
        d_v = 1'b1; d_a = ~a; d_b = ~b; d_yumi = 1'b1;
      end
    end
    check("d_product", o_p, exp_p);
    for (int h = 0; h < hold; h++) begin
      d_yumi = 1'b0; d_v = 1'b1; d_a = 8'($urandom); d_b = 8'($urandom);
      @(negedge clk);
      check("d_hold_v", o_vo, 1);
      check("d_hold_p_stable", o_p, exp_p);
      check("d_hold_ready", o_ready, 0);
    end
    // yumi together with v_i: the new operands must not be taken.
    d_yumi = 1'b1; d_v = 1'b1; d_a = 8'h5A; d_b = 8'hC3;
    @(negedge clk);
    check("d_after_yumi_ready", o_ready, 1);
    check("d_after_yumi_v", o_vo, 0);
    check("d_after_yumi_p", o_p, 0);
    d_yumi = 1'b0; d_v = 1'b0;
    @(negedge clk);
    check("d_no_accept_with_yumi", o_ready, 1);
  endtask

  // ---------------- random streams ----------------
  logic rstr_n = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : rnd
    localparam int W  = (g == 0) ? 16 : 4;
    localparam int EO = (g == 0) ? 1 : 0;
    localparam int N  = (g == 0) ? 4000 : 6000;
    localparam int BUDGET = 60000;

    logic             v, yumi, ready, vo;
    logic [W-1:0]     a, b;
    logic [2*W-1:0]   p;
    bit               fin = 1'b0;

    bsg_mul_comp42_seq #(.width_p(W), .early_out_p(EO)) dut (
      .clk_i(clk), .reset_n_i(rstr_n), .v_i(v), .a_i(a), .b_i(b),
      .ready_o(ready), .v_o(vo), .p_o(p), .yumi_i(yumi));

    // Model: idle, computing for a fixed number of cycles, or holding a product.
    bit               m_busy, m_done;
    int               m_wait, done_cnt;
    longint unsigned  m_prod;

    always @(posedge clk or negedge rstr_n) begin
      if (!rstr_n) begin
        m_busy <= 1'b0; m_done <= 1'b0; m_wait <= 0; m_prod <= 0; done_cnt <= 0;
      end else if (!m_busy && !m_done) begin
        if (v) begin
          m_busy <= 1'b1;
          m_wait <= busy_cycles(longint'(b), W, EO[0]) + 1;
          m_prod <= longint'(a) * longint'(b);
        end
      end else if (m_busy) begin
        if (m_wait == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
        m_wait <= m_wait - 1;
      end else if (yumi) begin
        m_done   <= 1'b0;
        done_cnt <= done_cnt + 1;
      end
    end

    // Compare every cycle once out of reset.
    always @(negedge clk) begin
      if (rstr_n) begin
        check($sformatf("w%0d_ready", W), ready, !(m_busy || m_done));
        check($sformatf("w%0d_v", W), vo, m_done);
        check($sformatf("w%0d_p", W), p, m_done ? m_prod : 0);
      end
    end

    initial begin
      int cyc;
      int ydly;
      logic [63:0] raw;
      int nb;
      cyc = 0; ydly = 0;
      v = 1'b0; yumi = 1'b0; a = '0; b = '0;
      @(posedge rstr_n);
      while (done_cnt < N && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
        raw = {$urandom, $urandom};
        nb  = $urandom_range(0, W);
        a = W'($urandom);
        b = W'(raw & ((64'd1 << nb) - 64'd1));
        if ($urandom_range(0, 3) == 0) b = W'(raw);
        v = ($urandom_range(0, 7) != 0);
        if (m_done) begin
          yumi = (ydly == 0);
          if (ydly != 0) ydly--;
        end else begin
          ydly = $urandom_range(0, 3);
          yumi = ($urandom_range(0, 7) == 0);
        end
      end
      v = 1'b0; yumi = 1'b0;
      check($sformatf("w%0d_completed_within_budget", W), done_cnt >= N, 1);
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check("reset_full_ready", f_ready, 1);
    check("reset_full_v", f_vo, 0);
    check("reset_full_p", f_p, 0);
    check("reset_early_ready", e_ready, 1);
    @(negedge clk);
    rst8_n = 1'b1;
    rstr_n = 1'b1;

    // Full-length 0xFF*0xFF: v_o from cycle 6.
    run_d(1'b0, 8'hFF, 8'hFF, 6, 16'hFE01, 0);
    // Early out: two BUSY cycles, and b=0 with one BUSY cycle.
    run_d(1'b1, 8'h03, 8'h05, 4, 16'h000F, 0);
    run_d(1'b1, 8'hAB, 8'h00, 3, 16'h0000, 0);
    // Backpressure for five cycles with new operands offered.
    run_d(1'b1, 8'h9C, 8'h7B, 6, 16'h4AF4, 5);

    // Reset in the second BUSY cycle of 0xFF*0xFF.
    sel = 1'b0; d_v = 1'b1; d_a = 8'hFF; d_b = 8'hFF;
    @(negedge clk);
    d_v = 1'b0;
    check("rst_mid_busy_pre_ready", f_ready, 0);
    @(negedge clk);
    #2 rst8_n = 1'b0;
    #1;
    check("rst_mid_busy_ready", f_ready, 1);
    check("rst_mid_busy_v", f_vo, 0);
    check("rst_mid_busy_p", f_p, 0);
    @(negedge clk);
    rst8_n = 1'b1;
    run_d(1'b0, 8'h12, 8'h34, 6, 16'h03A8, 0);

    // Reset while a product is being presented.
    sel = 1'b1; d_v = 1'b1; d_a = 8'h03; d_b = 8'h05;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      d_v = 1'b0;
    end
    check("rst_mid_done_pre_v", e_vo, 1);
    #2 rst8_n = 1'b0;
    #1;
    check("rst_mid_done_v", e_vo, 0);
    check("rst_mid_done_p", e_p, 0);
    check("rst_mid_done_ready", e_ready, 1);
    @(negedge clk);
    rst8_n = 1'b1;
    run_d(1'b1, 8'hFF, 8'hFF, 6, 16'hFE01, 0);

    wait (rnd[0].fin && rnd[1].fin);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bsg_mul_comp42_seq.md
BSG_MUL_COMP42_SEQ -- requirements
Module: bsg_mul_comp42_seq

Interface
REQ-001 The block SHALL have parameter width_p, default 16, meaning operand width; it SHALL be even and in the range 4..64.
REQ-002 The block SHALL have parameter early_out_p, default 1, meaning that early termination on exhausted multiplier bits is enabled when 1.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port v_i, input, 1 bit: operand valid.
REQ-006 The block SHALL have port a_i, input, width_p bits: multiplicand, unsigned.
REQ-007 The block SHALL have port b_i, input, width_p bits: multiplier, unsigned.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the block can accept operands.
REQ-009 The block SHALL have port v_o, output, 1 bit: product valid.
REQ-010 The block SHALL have port p_o, output, 2*width_p bits: product.
REQ-011 The block SHALL have port yumi_i, input, 1 bit: the consumer takes the product; it SHALL be asserted only while v_o=1.

Function
REQ-012 The block SHALL compute the product iteratively, two multiplier bits per cycle, using one carry-save 4:2 compressor stage of 2*width_p bits.
- The four compressor inputs are: sum accumulator, carry accumulator, pp0 = a & {b[2k]}, and pp1 = a & {b[2k+1]}.
- Both partial products are shifted left by 2k and 2k+1 respectively.
REQ-013 The block SHALL implement states IDLE, BUSY, FINAL and DONE, encoded in 2 bits.
REQ-014 In IDLE, ready_o SHALL be 1; in all other states ready_o SHALL be 0.
REQ-015 An accept SHALL occur when v_i & ready_o at a rising edge.
- On accept, the block latches a_i and b_i, clears the sum and carry accumulators, sets the pair counter k=0, and moves to BUSY.
- v_i while ready_o=0 SHALL be ignored.
REQ-016 Each BUSY cycle SHALL perform one compression step: the accumulators load the compressor sum and carry outputs, and k increments.
- The compressor's internal carry-out from the MSB is discarded, because the product fits in 2*width_p bits.
REQ-017 BUSY SHALL transition to FINAL when the step just performed has k = width_p/2-1.
- When early_out_p=1, BUSY SHALL also transition to FINAL when latched b bits [width_p-1 : 2k+2] are all zero.
- BUSY SHALL always last at least one cycle, including when b=0.
REQ-018 FINAL SHALL last exactly one cycle.
- In it, a carry-propagate add of the sum and carry accumulators, modulo 2^(2*width_p), is registered into the product register.
- The state then moves to DONE.
REQ-019 In DONE, v_o SHALL be 1 and p_o SHALL equal the product register.
- p_o SHALL remain stable until yumi_i.
- On yumi_i, the state SHALL move to IDLE; a new accept is possible no earlier than the next cycle.
REQ-020 Outside DONE, v_o SHALL be 0 and p_o SHALL be all zeros.
REQ-021 Latency with full iteration SHALL be: accept at edge 0; v_o=1 in the cycle after edge width_p/2+1, i.e. width_p/2+2 cycles after accept.
- With early out, v_o=1 in the cycle after edge n+1, where n is the number of BUSY cycles.
REQ-022 The arithmetic SHALL be exact for all operand pairs, including a=0, b=0, and all-ones operands.
REQ-023 yumi_i asserted outside DONE SHALL have no effect.
- Simultaneous yumi_i and v_i in DONE SHALL NOT accept the new operands.

Reset
REQ-024 reset_n_i=0 SHALL immediately and asynchronously force the following, regardless of current state, including mid-BUSY or mid-DONE:
- state IDLE;
- k, accumulators, latched operands and the product register to zero;
- v_o=0, p_o=0, ready_o=1.
REQ-025 After reset_n_i deasserts, the first accept SHALL be possible at the first rising edge.
- No partial result from before reset SHALL ever appear on p_o.

Verification (width_p=8 unless stated)
REQ-026 The bench SHALL cover full-length multiply: early_out_p=0, a=0xFF, b=0xFF accepted at edge 0 -> v_o=1 from cycle 6, p_o=0xFE01; yumi_i in cycle 6 -> ready_o=1 in cycle 7.
REQ-027 The bench SHALL cover early out: early_out_p=1, a=0x03, b=0x05 -> 2 BUSY cycles, v_o=1 from cycle 4, p_o=0x000F. Also b=0x00, a=0xAB -> 1 BUSY cycle, v_o=1 from cycle 3, p_o=0x0000.
REQ-028 The bench SHALL cover backpressure: after v_o=1, hold yumi_i=0 for 5 cycles while driving v_i=1 with new operands -> p_o stable, ready_o=0, no accept; yumi_i=1 -> IDLE next cycle.
REQ-029 The bench SHALL cover reset mid-operation: assert reset_n_i=0 asynchronously in the 2nd BUSY cycle of 0xFF*0xFF -> v_o=0, p_o=0, ready_o=1 immediately. After release, 0x12*0x34 -> p_o=0x03A8 with no stale data.
REQ-030 The bench SHALL cover random back-to-back operation: width_p=16 and width_p=4, at least 10000 random operand pairs with random yumi_i delay 0..3 -> every p_o equals a*b, and latency matches REQ-021.
